hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Producer-side companion to forwarding in the 5-stage pipeline.
- Tracks destinations of in-flight instructions in EX and MEM with its own scoreboard.
- Detects hazards that forwarding cannot cover: load-use, data-memory wait, instruction-memory wait, and taken branch/jump.
- Drives enable and flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches; sits beside the datapath controller.

Parameters:
- REG_W, 5, register-select width.
- STAT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- nRST  in  1  async active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dmem_req_o3  in  1  MEM-stage instruction has dREN or dWEN asserted.
- id_rsel1, id_rsel2  in  REG_W  decode source registers.
- id_use1, id_use2  in  1  decode instruction reads rsel1 / rsel2.
- id_wen  in  1  decode instruction writes a register.
- id_wsel  in  REG_W  decode destination register.
- id_memread  in  1  decode instruction is a load.
- br_taken_ex  in  1  branch/jump resolved taken in EX.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  latch enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  insert bubble on enable.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Reset (async, nRST=0): state RUN; scoreboard cleared to invalid; all enables 0; all flushes 0.
- Scoreboard: ex_slot and mem_slot, each {valid, wsel, memread}.
  - On idex_en, ex_slot loads decode info (valid=id_wen & id_wsel!=0); it loads invalid if idex_flush.
  - On exmem_en, mem_slot takes ex_slot; it takes invalid if exmem_flush.
- load_use = ex_slot.valid & ex_slot.memread & ((id_use1 & id_rsel1==ex_slot.wsel) | (id_use2 & id_rsel2==ex_slot.wsel)).
- dwait = dmem_req_o3 & ~dhit.
- Outputs are combinational from state and inputs, evaluated in priority order below.
- Priority 1, dwait: all enables 0 except memwb_en=1 with memwb_flush=1 (one bubble into WB per cycle, no duplicate writeback). Next state DWAIT; stay there until dhit. The dhit cycle behaves as RUN.
- Priority 2, br_taken_ex (RUN only):
  - pc_en=1 (controller loads target); ifid_en=idex_en=1 with ifid_flush=idex_flush=1; exmem_en=memwb_en=1.
  - If ihit=0 this cycle, the outstanding fetch is wrong-path: next state FLUSH_PEND.
- Priority 3, load_use: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1 (exactly one bubble); exmem_en=memwb_en=1. Recomputed each cycle; it clears once the load leaves EX.
- Priority 4, ~ihit: pc_en=0, ifid_en=1 with ifid_flush=1; downstream stages advance.
- Otherwise: all enables 1, flushes 0.
- FLUSH_PEND:
  - Downstream advances as RUN; pc_en=0.
  - On ihit the fetched word is discarded: ifid_flush=1, pc_en=1, next state RUN.
  - A dwait in FLUSH_PEND takes priority but returns to FLUSH_PEND afterwards, via saved bit pend_r.
- Simultaneous load_use and br_taken_ex: branch wins; the stalled decode instruction is flushed anyway.
- The register $0 never causes a hazard.
- States encoded RUN=0, DWAIT=1, FLUSH_PEND=2.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds output ports stall_cnt, flush_cnt, dwait_cnt (each STAT_W).
  - stall_cnt counts load-use bubble cycles.
  - flush_cnt counts taken-branch flush events.
  - dwait_cnt counts cycles in which dwait=1.
  - Counters saturate at all-ones and clear on reset.
- When not defined, the ports and counters are absent; no other behaviour changes.

Decomposition:
- diaosi_types_pkg: hazard_state_t enum (RUN, DWAIT, FLUSH_PEND) and sb_entry_t struct {valid, wsel, memread}.
- One sub-module, hazard_scoreboard: the two-slot shift register plus the load_use comparator.
- The FSM and output priority logic stay in hazard_unit.

Test Plan:
- Reset mid-run: assert nRST=0 with state=DWAIT -> state_o=0 and all enables 0 immediately; after release with ihit=1 -> all enables 1.
- Load-use: lw $5 in EX, decode reads $5 via rsel2 with id_use2=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal. Same case with wsel=$0 -> no stall.
- Data wait: dmem_req_o3=1 with dhit low for 3 cycles -> 3 cycles with pc_en..exmem_en=0 and memwb_flush=1; the dhit cycle gives all enables 1.
- Branch during imem miss: br_taken_ex=1, ihit=0 -> ifid_flush=1 and idex_flush=1; state=FLUSH_PEND. ihit two cycles later -> ifid_flush=1, pc_en=1, state RUN.
- Branch and load-use in the same cycle -> flush outputs asserted, pc_en=1, no stall.
- HAZARD_STATS_EN build: 2 load-use stalls, 1 flush, 4 dwait cycles -> stall_cnt=2, flush_cnt=1, dwait_cnt=4.

Source files
------------

// File: rtl/diaosi_types_pkg.sv
// Shared types for the hazard unit: FSM states, scoreboard entries and the
// bundle of latch enable/flush controls driven toward the datapath.
package diaosi_types_pkg;

   // Register-select width baked into the scoreboard entry; hazard_unit's REG_W must match it.
   localparam int SB_REG_W = 5;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      DWAIT      = 2'd1,
      FLUSH_PEND = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic                valid;
      logic [SB_REG_W-1:0] wsel;
      logic                memread;
   } sb_entry_t;

   localparam sb_entry_t SB_INVALID = '0;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
   } hazard_ctrl_t;

   localparam hazard_ctrl_t CTRL_NONE = '0;
   localparam hazard_ctrl_t CTRL_FLOW = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                          exmem_en: 1'b1, memwb_en: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot destination scoreboard mirroring the EX and MEM pipeline latches,
// plus the load-use comparator against the instruction sitting in decode.
module hazard_scoreboard
   import diaosi_types_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                idex_en,
   input  logic                idex_flush,
   input  logic                exmem_en,
   input  logic                exmem_flush,
   input  logic                id_wen,
   input  logic [SB_REG_W-1:0] id_wsel,
   input  logic                id_memread,
   input  logic [SB_REG_W-1:0] id_rsel1,
   input  logic [SB_REG_W-1:0] id_rsel2,
   input  logic                id_use1,
   input  logic                id_use2,
   output logic                load_use
);

   sb_entry_t ex_q, ex_d;
   sb_entry_t mem_q, mem_d;

   // Non-writing instructions and writes to $0 are stored as all-zero entries,
   // so a valid slot always names a real register and $0 never matches.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      if (idex_en) begin
         if (idex_flush || !id_wen || (id_wsel == '0)) begin
            ex_d = SB_INVALID;
         end else begin
            ex_d = '{valid: 1'b1, wsel: id_wsel, memread: id_memread};
         end
      end
      if (exmem_en) begin
         mem_d = exmem_flush ? SB_INVALID : ex_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= SB_INVALID;
         mem_q <= SB_INVALID;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
      end
   end

   assign load_use = ex_q.valid && ex_q.memread &&
                     ((id_use1 && (id_rsel1 == ex_q.wsel)) ||
                      (id_use2 && (id_rsel2 == ex_q.wsel)));

   // MEM slot invariant: valid entries name a nonzero register, invalid ones are cleared.
   a_mem_slot_shape : assert property (@(posedge clk) disable iff (!rst_n)
      (mem_q.valid ? (mem_q.wsel != '0) : (mem_q == SB_INVALID)));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stalls/flushes the PC and pipeline latches for load-use,
// memory waits and taken branches. Optional statistics counters: HAZARD_STATS_EN.
module hazard_unit
   import diaosi_types_pkg::*;
#(
   parameter int REG_W = SB_REG_W
`ifdef HAZARD_STATS_EN
   , parameter int STAT_W = 32
`endif
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmem_req_o3,
   input  logic [REG_W-1:0] id_rsel1,
   input  logic [REG_W-1:0] id_rsel2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic             id_wen,
   input  logic [REG_W-1:0] id_wsel,
   input  logic             id_memread,
   input  logic             br_taken_ex,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic [1:0]       state_o
`ifdef HAZARD_STATS_EN
   ,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt,
   output logic [STAT_W-1:0] dwait_cnt
`endif
);

   hazard_state_t state_q, state_d, eff_state;
   logic          pend_q, pend_d;
   hazard_ctrl_t  ctrl_raw, ctrl;
   logic          load_use;
   logic          dwait;
   logic          stall_ev, flush_ev;

   assign dwait = dmem_req_o3 && !dhit;

   hazard_scoreboard u_scoreboard (
      .clk         (CLK),
      .rst_n       (nRST),
      .idex_en     (ctrl.idex_en),
      .idex_flush  (ctrl.idex_flush),
      .exmem_en    (ctrl.exmem_en),
      .exmem_flush (ctrl.exmem_flush),
      .id_wen      (id_wen),
      .id_wsel     (id_wsel),
      .id_memread  (id_memread),
      .id_rsel1    (id_rsel1),
      .id_rsel2    (id_rsel2),
      .id_use1     (id_use1),
      .id_use2     (id_use2),
      .load_use    (load_use)
   );

   // DWAIT resumes whichever state it interrupted (pend_q), so the cycle dhit
   // arrives behaves exactly like that state.
   always_comb begin
      ctrl_raw  = CTRL_FLOW;
      state_d   = state_q;
      pend_d    = pend_q;
      stall_ev  = 1'b0;
      flush_ev  = 1'b0;
      eff_state = state_q;
      if (state_q == DWAIT) begin
         eff_state = pend_q ? FLUSH_PEND : RUN;
      end

      if (dwait) begin
         ctrl_raw             = CTRL_NONE;
         ctrl_raw.memwb_en    = 1'b1;
         ctrl_raw.memwb_flush = 1'b1;
         state_d              = DWAIT;
         pend_d               = (eff_state == FLUSH_PEND);
      end else if (eff_state == FLUSH_PEND) begin
         pend_d              = 1'b0;
         ctrl_raw.ifid_flush = 1'b1;
         if (ihit) begin
            state_d = RUN;
         end else begin
            ctrl_raw.pc_en = 1'b0;
            state_d        = FLUSH_PEND;
         end
      end else begin
         pend_d  = 1'b0;
         state_d = RUN;
         if (br_taken_ex) begin
            ctrl_raw.ifid_flush = 1'b1;
            ctrl_raw.idex_flush = 1'b1;
            flush_ev            = 1'b1;
            if (!ihit) begin
               state_d = FLUSH_PEND;
            end
         end else if (load_use) begin
            ctrl_raw.pc_en      = 1'b0;
            ctrl_raw.ifid_en    = 1'b0;
            ctrl_raw.idex_flush = 1'b1;
            stall_ev            = 1'b1;
         end else if (!ihit) begin
            ctrl_raw.pc_en      = 1'b0;
            ctrl_raw.ifid_flush = 1'b1;
         end
      end
   end

   // Reset must freeze every latch immediately, not just from the next edge.
   always_comb begin
      ctrl = CTRL_NONE;
      if (nRST) begin
         ctrl = ctrl_raw;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign idex_en     = ctrl.idex_en;
   assign exmem_en    = ctrl.exmem_en;
   assign memwb_en    = ctrl.memwb_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_flush = ctrl.exmem_flush;
   assign memwb_flush = ctrl.memwb_flush;
   assign state_o     = state_q;

`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [STAT_W-1:0] dwait_cnt_q, dwait_cnt_d;

   // Saturating event counters; they hold at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      dwait_cnt_d = dwait_cnt_q;
      if (stall_ev && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STAT_W'(1);
      end
      if (flush_ev && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + STAT_W'(1);
      end
      if (dwait && (dwait_cnt_q != '1)) begin
         dwait_cnt_d = dwait_cnt_q + STAT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         dwait_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         dwait_cnt_q <= dwait_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign dwait_cnt = dwait_cnt_q;
`endif

endmodule
